load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: turns a RISC-V load/store request from the MEM stage into data-memory commands.
- Drives MemRead, MemWrite, address and write_data; consumes read_data.
- The memory is word-wide and word-addressed, so the unit handles byte and half sub-word access. Sub-word stores use read-modify-write; loads are extended.
- Returns a single-cycle response to the pipeline.

Parameters:
READ_LATENCY, 1, cycles MemRead/address are held before read_data is sampled (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, can accept request
req_we  input  1  1 = store, 0 = load
funct3  input  3  RISC-V width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU)
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result (0 for stores/errors)
resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
address  output  32  word index = {2'b00, addr[31:2]}
write_data  output  32  word to write
read_data  input  32  word returned by memory

Behaviour:
- Reset:
  - Asynchronous; all outputs and registers clear immediately.
  - State goes to IDLE.
  - Values on reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, address=0, write_data=0.
- Request accept:
  - A request is accepted when req_valid && req_ready at a rising edge.
  - addr, wdata, we and funct3 are latched at acceptance.
  - req_ready=1 only in IDLE; no new request is accepted until after RESP.
- Memory outputs:
  - Driven only from state and latched registers.
  - No combinational path from any req_* input.
- States:
  - IDLE:
    - Store word (SW) -> WR.
    - Load, or store byte/half (SB/SH) -> RD.
    - Error -> RESP.
  - RD:
    - MemRead=1, address=word index, held for READ_LATENCY cycles.
    - read_data is sampled at the last edge.
    - Load -> RESP; SB/SH -> WR.
  - WR:
    - MemWrite=1 for exactly one cycle.
    - write_data = req_wdata for SW, or the merged word for SB/SH.
    - Next state -> RESP.
  - RESP:
    - resp_valid=1 for one cycle; resp_rdata and resp_err are valid.
    - Next state -> IDLE; resp_rdata/resp_err hold until the next RESP.
- Sub-word merge:
  - SB replaces byte addr[1:0] of the sampled word with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other bits are preserved.
- Load extract: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- MemRead and MemWrite are never asserted in the same cycle.
- Latency, in cycles from the accept edge to resp_valid high (R = READ_LATENCY):
  - Loads: R+1.
  - SW: 2.
  - SB/SH: R+2.
  - Error: 1.
- Errors:
  - Error conditions:
    - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
    - Illegal funct3: 3/6/7 on a load; anything other than 0/1/2 on a store.
  - Error handling:
    - No memory access is performed.
    - resp_err=1, resp_rdata=0.
- Reset mid-operation:
  - In-flight operation is dropped; no response is issued.
  - MemRead/MemWrite deassert asynchronously.
  - A partially completed RMW never writes.
- Address width: address[31:30] are always 0; there is no wrap handling beyond truncation of addr[1:0].

Test Plan:
- Memory word 2 = 0x8000F0A5; LW req_addr 0x08 -> MemRead=1 with address=2 for 1 cycle; resp_valid 2 cycles after accept; resp_rdata=0x8000F0A5, resp_err=0.
- Same word, one test per load:
  - LB 0x08 -> 0xFFFFFFA5.
  - LBU 0x09 -> 0x000000F0.
  - LH 0x0A -> 0xFFFF8000.
  - LHU 0x0A -> 0x00008000.
- SW req_addr 0x1C, wdata 0x16CDEFFF -> single MemWrite pulse with address=7, write_data=0x16CDEFFF, no MemRead; resp 2 cycles after accept. A following LW 0x1C returns 0x16CDEFFF.
- Word 7 = 0x16CDEFFF; SB req_addr 0x1D, wdata 0x123456AB -> MemRead at address 7, then MemWrite with write_data=0x16CDABFF; resp 3 cycles after accept. SH 0x1E, wdata 0x0000BEEF -> write_data=0xBEEFABFF.
- Error cases: LW 0x06, SH 0x03, and load funct3=3 -> each gives resp_valid+resp_err 1 cycle after accept, resp_rdata=0, MemRead/MemWrite never asserted, req_ready low only during that one cycle.
- Reset during RD of SB 0x1D:
  - MemRead drops in the same cycle reset rises.
  - No MemWrite and no resp_valid follow; word 7 is unchanged.
  - req_ready=1 after reset release; back-to-back requests with req_valid held high are each accepted only in IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of a word-wide, word-addressed data memory. Accepts one
//   RISC-V load/store request at a time from the MEM stage, performs the
//   memory access (read-modify-write for SB/SH), and returns a one-cycle
//   response with the extended load data or an error flag.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, funct3      store/load select and RISC-V width/sign code
//   req_addr, req_wdata byte address and store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata/resp_err extended load data / misaligned-or-illegal flag
//   MemRead, MemWrite   memory enables (never both high)
//   address             word index {2'b00, addr[31:2]}
//   write_data          word written to memory
//   read_data           word returned by memory
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;   // store data, replaced by the merged word for SB/SH
    logic          we_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] cnt;
    logic          rd_last;
    logic          req_is_err;

    // Misaligned access or funct3 code that is illegal for the direction.
    function automatic logic decode_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic e;
        e = 1'b0;
        if (we && f3[2]) begin
            e = 1'b1;
        end else begin
            case (f3)
                3'd0, 3'd4: e = 1'b0;
                3'd1, 3'd5: e = a[0];
                3'd2:       e = (a != 2'b00);
                default:    e = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'd0:    r = {{24{b[7] & ~f3[2]}}, b};
            2'd1:    r = {{16{h[15] & ~f3[2]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [31:0] d,
                                                input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (f3[0]) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    assign rd_last    = (cnt == CW'(READ_LATENCY - 1));
    assign req_is_err = decode_err(req_we, funct3, req_addr[1:0]);

    // State register plus latched request / response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        f3_q    <= funct3;
                        cnt     <= '0;
                        if (req_is_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (rd_last) begin
                        if (we_q) begin
                            wdata_q <= store_merge(read_data, wdata_q, f3_q, addr_q[1:0]);
                        end else begin
                            resp_rdata <= load_extract(read_data, f3_q, addr_q[1:0]);
                            resp_err   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_is_err)
                        next_state = S_RESP;
                    else if (req_we && funct3 == 3'd2)
                        next_state = S_WR;
                    else
                        next_state = S_RD;
                end
            end
            S_RD:    if (rd_last) next_state = we_q ? S_WR : S_RESP;
            S_WR:    next_state = S_RESP;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs depend only on state and latched registers
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        MemRead    = (state == S_RD);
        MemWrite   = (state == S_WR);
        address    = '0;
        write_data = '0;
        if (state == S_RD || state == S_WR)
            address = {2'b00, addr_q[31:2]};
        if (state == S_WR)
            write_data = wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .funct3(funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Simple word memory (64 words) with a preload port
    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (MemWrite) mem[address[5:0]] <= write_data;
    end
    assign read_data = mem[address[5:0]];

    // Reference: byte-addressed little-endian memory image
    logic [7:0] rb [256];

    function automatic logic [31:0] ref_word(input int idx);
        return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        size = 1 << f3[1:0];
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v = '0;
        for (int unsigned i = 0; i < size; i++)
            v = v | (32'(rb[(int'(a[7:0]) + i) % 256]) << (8 * i));
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned size;
        size = 1 << f3[1:0];
        for (int unsigned i = 0; i < size; i++)
            rb[(int'(a[7:0]) + i) % 256] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    function automatic int exp_lat(input logic we, input logic [2:0] f3, input logic e);
        if (e) return 1;
        if (!we) return RL + 1;
        if (f3 == 3'd2) return 2;
        return RL + 2;
    endfunction

    function automatic int exp_nrd(input logic we, input logic [2:0] f3, input logic e);
        if (e) return 0;
        if (we && f3 == 3'd2) return 0;
        return RL;
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'(idx); pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
        for (int b = 0; b < 4; b++) rb[4*idx+b] = d[8*b +: 8];
    endtask

    // Issues one request and observes the bus until resp_valid (bounded)
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat, output int nrd, output int nwr, output int rdy_hi,
                          output logic [31:0] wseen, output logic bad_addr,
                          output logic overlap, output logic tmo);
        rd = '0; e = 1'b0; lat = 0; nrd = 0; nwr = 0; rdy_hi = 0; wseen = '0;
        bad_addr = 1'b0; overlap = 1'b0; tmo = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (MemRead) begin
                nrd++;
                if (address !== {2'b00, a[31:2]}) bad_addr = 1'b1;
            end
            if (MemWrite) begin
                nwr++;
                wseen = write_data;
                if (address !== {2'b00, a[31:2]}) bad_addr = 1'b1;
            end
            if (MemRead && MemWrite) overlap = 1'b1;
            if (req_ready) rdy_hi++;
            if (resp_valid) begin
                rd = resp_rdata; e = resp_err; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
        checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL rst_memread got %b want 0", MemRead); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b want 0", MemWrite); end
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL rst_address got %h want 0", address); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", write_data); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as   [5] = '{32'h08, 32'h08, 32'h09, 32'h0A, 32'h0A};
        logic [31:0] exps [5] = '{32'h8000F0A5, 32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8000, 32'h00008000};
        logic [31:0] rd, ws; logic e, ba, ov, tmo; int lat, nrd, nwr, rh;
        poke(2, 32'h8000F0A5);
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, f3s[i], as[i], 32'h0, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL load%0d_timeout got %b want 0", i, tmo); end
            checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, exps[i]); end
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL load%0d_err got %b want 0", i, e); end
            checks++; if (lat != RL + 1) begin errors++; $display("FAIL load%0d_latency got %0d want %0d", i, lat, RL + 1); end
            checks++; if (nrd != RL || nwr != 0 || ba) begin errors++; $display("FAIL load%0d_bus got rd=%0d wr=%0d badaddr=%b want rd=%0d wr=0 badaddr=0", i, nrd, nwr, ba, RL); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd, ws; logic e, ba, ov, tmo; int lat, nrd, nwr, rh;
        run_op(1'b1, 3'd2, 32'h1C, 32'h16CDEFFF, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
        ref_store(3'd2, 32'h1C, 32'h16CDEFFF);
        checks++; if (ws !== 32'h16CDEFFF || nwr != 1 || nrd != 0 || ba) begin errors++; $display("FAIL sw_bus got wd=%h wr=%0d rd=%0d badaddr=%b want wd=16cdefff wr=1 rd=0 badaddr=0", ws, nwr, nrd, ba); end
        checks++; if (lat != 2 || e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=0", lat, e, rd); end
        run_op(1'b0, 3'd2, 32'h1C, 32'h0, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
        checks++; if (rd !== 32'h16CDEFFF) begin errors++; $display("FAIL sw_readback got %h want 16cdefff", rd); end
        run_op(1'b1, 3'd0, 32'h1D, 32'h123456AB, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
        ref_store(3'd0, 32'h1D, 32'h123456AB);
        checks++; if (ws !== 32'h16CDABFF || nwr != 1 || nrd != RL || ov || ba) begin errors++; $display("FAIL sb_bus got wd=%h wr=%0d rd=%0d overlap=%b badaddr=%b want wd=16cdabff wr=1 rd=%0d", ws, nwr, nrd, ov, ba, RL); end
        checks++; if (lat != RL + 2 || e !== 1'b0) begin errors++; $display("FAIL sb_resp got lat=%0d err=%b want lat=%0d err=0", lat, e, RL + 2); end
        run_op(1'b1, 3'd1, 32'h1E, 32'h0000BEEF, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
        ref_store(3'd1, 32'h1E, 32'h0000BEEF);
        checks++; if (ws !== 32'hBEEFABFF || nwr != 1 || nrd != RL || ov) begin errors++; $display("FAIL sh_bus got wd=%h wr=%0d rd=%0d overlap=%b want wd=beefabff wr=1 rd=%0d", ws, nwr, nrd, ov, RL); end
        checks++; if (mem[7] !== 32'hBEEFABFF) begin errors++; $display("FAIL sh_memword got %h want beefabff", mem[7]); end
    endtask

    task automatic test_errors();
        logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [3] = '{3'd2, 3'd1, 3'd3};
        logic [31:0] as   [3] = '{32'h06, 32'h03, 32'h08};
        logic [31:0] rd, ws; logic e, ba, ov, tmo; int lat, nrd, nwr, rh;
        for (int i = 0; i < 3; i++) begin
            run_op(wes[i], f3s[i], as[i], 32'hFFFFFFFF, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
            checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err%0d_resp got err=%b rdata=%h want err=1 rdata=0", i, e, rd); end
            checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency got %0d want 1", i, lat); end
            checks++; if (nrd != 0 || nwr != 0 || rh != 0) begin errors++; $display("FAIL err%0d_bus got rd=%0d wr=%0d ready_hi=%0d want 0 0 0", i, nrd, nwr, rh); end
            @(negedge clk);
            checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b1) begin errors++; $display("FAIL err%0d_after got ready=%b valid=%b err=%b want 1 0 1", i, req_ready, resp_valid, resp_err); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ws, a, exp_rd, exp_ws; logic e, ba, ov, tmo, we, exp_e;
        logic [2:0] f3; int lat, nrd, nwr, rh;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom);
            ws = $urandom;
            exp_e  = ref_err(we, f3, a);
            exp_rd = (!we && !exp_e) ? ref_load(f3, a) : 32'h0;
            if (a[31:8] != 0 && !exp_e) a[31:8] = '0;
            if (we && !exp_e) ref_store(f3, a, ws);
            exp_ws = ref_word(int'(a[7:2]));
            run_op(we, f3, a, ws, rd, e, lat, nrd, nwr, rh, ws, ba, ov, tmo);
            checks++; if (tmo !== 1'b0 || rd !== exp_rd || e !== exp_e) begin errors++; $display("FAIL rnd%0d_resp we=%b f3=%0d a=%h got rdata=%h err=%b tmo=%b want rdata=%h err=%b", n, we, f3, a, rd, e, tmo, exp_rd, exp_e); end
            checks++; if (lat != exp_lat(we, f3, exp_e) || nrd != exp_nrd(we, f3, exp_e) || nwr != int'(we && !exp_e)) begin errors++; $display("FAIL rnd%0d_timing got lat=%0d rd=%0d wr=%0d want lat=%0d rd=%0d wr=%0d", n, lat, nrd, nwr, exp_lat(we, f3, exp_e), exp_nrd(we, f3, exp_e), int'(we && !exp_e)); end
            checks++; if (ov || ba || rh != 0) begin errors++; $display("FAIL rnd%0d_bus got overlap=%b badaddr=%b ready_hi=%0d want 0 0 0", n, ov, ba, rh); end
            if (we && !exp_e) begin
                checks++; if (ws !== exp_ws) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, ws, exp_ws); end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd0; req_addr = 32'h1D; req_wdata = 32'h000000CC;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL midop_inrd got %b want 1", MemRead); end
        reset = 1'b1;
        #1;
        checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL midop_async got rd=%b wr=%b valid=%b want 0 0 0", MemRead, MemWrite, resp_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (MemWrite || resp_valid || MemRead) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_quiet got activity=%b want 0", seen); end
        checks++; if (mem[7] !== ref_word(7)) begin errors++; $display("FAIL midop_word7 got %h want %h", mem[7], ref_word(7)); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_ready got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int p;
        logic [31:0] exp_rd;
        p = RL + 2;
        exp_rd = ref_load(3'd0, 32'h0B);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd0; req_addr = 32'h0B; req_wdata = '0;
        for (int i = 0; i < 3 * p; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (req_ready !== (i % p == 0)) begin errors++; $display("FAIL b2b%0d_ready got %b want %b", i, req_ready, (i % p == 0)); end
            checks++; if (resp_valid !== (i % p == p - 1)) begin errors++; $display("FAIL b2b%0d_valid got %b want %b", i, resp_valid, (i % p == p - 1)); end
            if (i % p == p - 1) begin
                checks++; if (resp_rdata !== exp_rd) begin errors++; $display("FAIL b2b%0d_rdata got %h want %h", i, resp_rdata, exp_rd); end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = '0;
        req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        test_loads();
        test_stores();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
